// File: rtl/inpkt_header_chk_if.sv
// rtl/inpkt_header_chk_if.sv - byte input and parsed-header/status bundle for inpkt_header_chk
interface inpkt_header_chk_if #(
  parameter int PKT_TYPE_MSB = 2
);
  logic [7:0]            din;
  logic                  wr_en;
  logic                  err_clear;
  logic [PKT_TYPE_MSB:0] pkt_type;
  logic [15:0]           pkt_id;
  logic                  pkt_data;
  logic                  pkt_end;
  logic                  err;
  logic                  err_pkt_version;
  logic                  err_pkt_type;
  logic                  err_pkt_len;
  logic                  err_pkt_checksum;

  modport master (
    output din, wr_en, err_clear,
    input  pkt_type, pkt_id, pkt_data, pkt_end, err,
    input  err_pkt_version, err_pkt_type, err_pkt_len, err_pkt_checksum
  );

  modport slave (
    input  din, wr_en, err_clear,
    output pkt_type, pkt_id, pkt_data, pkt_end, err,
    output err_pkt_version, err_pkt_type, err_pkt_len, err_pkt_checksum
  );
endinterface

// File: rtl/inpkt_header_chk.sv
// rtl/inpkt_header_chk.sv - input packet header parser with header/data checksum verification
// Optional: INPKT_ERR_CLEAR_EN lets err_clear return the parser from ERROR to VERSION.
module inpkt_header_chk #(
  parameter int VERSION           = 2,
  parameter int PKT_MAX_LEN       = 65536,
  parameter int PKT_MAX_TYPE      = 7,
  parameter int PKT_TYPE_MSB      = $clog2(PKT_MAX_TYPE + 1) - 1,
  parameter int CHECKSUM_INTERVAL = 0
) (
  input logic               CLK,
  input logic               RESET,
  inpkt_header_chk_if.slave bus
);

  typedef enum logic [3:0] {
    S_VERSION, S_TYPE, S_RSV0_0, S_RSV0_1, S_LEN0, S_LEN1, S_LEN2,
    S_RSV1, S_ID0, S_ID1, S_CHECKSUM, S_DATA, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [PKT_TYPE_MSB:0] pkt_type_q, pkt_type_d;
  logic                  type_ok_q, type_ok_d;
  logic [15:0]           pkt_id_q, pkt_id_d;
  logic [23:0]           len_q, len_d;
  logic [23:0]           byte_count_q, byte_count_d;
  logic [23:0]           byte_count_max_q, byte_count_max_d;
  logic [23:0]           since_q, since_d;
  logic [31:0]           sum_q, sum_d;
  logic [1:0]            pos_q, pos_d;
  logic [23:0]           tmp_q, tmp_d;
  logic [1:0]            ck_idx_q, ck_idx_d;
  logic                  final_q, final_d;
  logic                  err_ver_q, err_ver_d;
  logic                  err_type_q, err_type_d;
  logic                  err_len_q, err_len_d;
  logic                  err_ck_q, err_ck_d;
  logic                  pkt_data;
  logic [31:0]           sum_add;

  // Adding each byte at its lane offset equals summing zero-padded LE words mod 2^32.
  assign sum_add = sum_q + ({24'b0, bus.din} << {pos_q, 3'b000});

  always_comb begin
    state_d          = state_q;
    pkt_type_d       = pkt_type_q;
    type_ok_d        = type_ok_q;
    pkt_id_d         = pkt_id_q;
    len_d            = len_q;
    byte_count_d     = byte_count_q;
    byte_count_max_d = byte_count_max_q;
    since_d          = since_q;
    sum_d            = sum_q;
    pos_d            = pos_q;
    tmp_d            = tmp_q;
    ck_idx_d         = ck_idx_q;
    final_d          = final_q;
    err_ver_d        = err_ver_q;
    err_type_d       = err_type_q;
    err_len_d        = err_len_q;
    err_ck_d         = err_ck_q;
    pkt_data         = 1'b0;

    if (bus.wr_en) begin
      case (state_q)
        S_VERSION: begin
          if (bus.din != 8'h00) begin
            if (bus.din == 8'(VERSION)) begin
              sum_d   = sum_add;
              pos_d   = pos_q + 2'd1;
              state_d = S_TYPE;
            end else begin
              err_ver_d = 1'b1;
              state_d   = S_ERROR;
            end
          end
        end
        S_TYPE: begin
          pkt_type_d = bus.din[PKT_TYPE_MSB:0];
          type_ok_d  = (bus.din != 8'h00) && (32'(bus.din) <= 32'(PKT_MAX_TYPE)) &&
                       ((32'(bus.din) >> (PKT_TYPE_MSB + 1)) == 32'd0);
          sum_d      = sum_add;
          pos_d      = pos_q + 2'd1;
          state_d    = S_RSV0_0;
        end
        S_RSV0_0: begin
          if (!type_ok_q) begin
            err_type_d = 1'b1;
            state_d    = S_ERROR;
          end else begin
            sum_d   = sum_add;
            pos_d   = pos_q + 2'd1;
            state_d = S_RSV0_1;
          end
        end
        S_RSV0_1, S_LEN0, S_LEN1, S_LEN2, S_ID0: begin
          sum_d = sum_add;
          pos_d = pos_q + 2'd1;
          case (state_q)
            S_RSV0_1: state_d = S_LEN0;
            S_LEN0:   begin len_d[7:0]   = bus.din; state_d = S_LEN1; end
            S_LEN1:   begin len_d[15:8]  = bus.din; state_d = S_LEN2; end
            S_LEN2:   begin len_d[23:16] = bus.din; state_d = S_RSV1; end
            default:  begin pkt_id_d[7:0] = bus.din; state_d = S_ID1; end
          endcase
        end
        S_RSV1: begin
          if ((len_q == 24'd0) || (32'(len_q) > 32'(PKT_MAX_LEN))) begin
            err_len_d = 1'b1;
            state_d   = S_ERROR;
          end else begin
            byte_count_max_d = len_q - 24'd1;
            byte_count_d     = 24'd0;
            since_d          = 24'd0;
            sum_d            = sum_add;
            pos_d            = pos_q + 2'd1;
            state_d          = S_ID0;
          end
        end
        S_ID1: begin
          pkt_id_d[15:8] = bus.din;
          sum_d          = sum_add;
          pos_d          = pos_q + 2'd1;
          ck_idx_d       = 2'd0;
          final_d        = 1'b0;
          state_d        = S_CHECKSUM;
        end
        S_CHECKSUM: begin
          if (ck_idx_q == 2'd3) begin
            ck_idx_d = 2'd0;
            if ({bus.din, tmp_q} != ~sum_q) begin
              err_ck_d = 1'b1;
              state_d  = S_ERROR;
            end else begin
              sum_d   = 32'd0;
              pos_d   = 2'd0;
              final_d = 1'b0;
              state_d = final_q ? S_VERSION : S_DATA;
            end
          end else begin
            case (ck_idx_q)
              2'd0:    tmp_d[7:0]   = bus.din;
              2'd1:    tmp_d[15:8]  = bus.din;
              default: tmp_d[23:16] = bus.din;
            endcase
            ck_idx_d = ck_idx_q + 2'd1;
          end
        end
        S_DATA: begin
          pkt_data = 1'b1;
          sum_d    = sum_add;
          pos_d    = pos_q + 2'd1;
          if (byte_count_q == byte_count_max_q) begin
            final_d = 1'b1;
            state_d = S_CHECKSUM;
          end else begin
            byte_count_d = byte_count_q + 24'd1;
            since_d      = since_q + 24'd1;
            if ((CHECKSUM_INTERVAL != 0) && (32'(since_q) + 32'd1 == 32'(CHECKSUM_INTERVAL))) begin
              since_d = 24'd0;
              state_d = S_CHECKSUM;
            end
          end
        end
        default: ;
      endcase
    end

`ifdef INPKT_ERR_CLEAR_EN
    // Clear overrides any byte presented in the same cycle.
    if (bus.err_clear) begin
      state_d      = S_VERSION;
      err_ver_d    = 1'b0;
      err_type_d   = 1'b0;
      err_len_d    = 1'b0;
      err_ck_d     = 1'b0;
      sum_d        = 32'd0;
      pos_d        = 2'd0;
      tmp_d        = 24'd0;
      ck_idx_d     = 2'd0;
      final_d      = 1'b0;
      byte_count_d = 24'd0;
      since_d      = 24'd0;
      pkt_data     = 1'b0;
    end
`else
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q          <= S_VERSION;
      pkt_type_q       <= '0;
      type_ok_q        <= 1'b0;
      pkt_id_q         <= 16'd0;
      len_q            <= 24'd0;
      byte_count_q     <= 24'd0;
      byte_count_max_q <= 24'd0;
      since_q          <= 24'd0;
      sum_q            <= 32'd0;
      pos_q            <= 2'd0;
      tmp_q            <= 24'd0;
      ck_idx_q         <= 2'd0;
      final_q          <= 1'b0;
      err_ver_q        <= 1'b0;
      err_type_q       <= 1'b0;
      err_len_q        <= 1'b0;
      err_ck_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pkt_type_q       <= pkt_type_d;
      type_ok_q        <= type_ok_d;
      pkt_id_q         <= pkt_id_d;
      len_q            <= len_d;
      byte_count_q     <= byte_count_d;
      byte_count_max_q <= byte_count_max_d;
      since_q          <= since_d;
      sum_q            <= sum_d;
      pos_q            <= pos_d;
      tmp_q            <= tmp_d;
      ck_idx_q         <= ck_idx_d;
      final_q          <= final_d;
      err_ver_q        <= err_ver_d;
      err_type_q       <= err_type_d;
      err_len_q        <= err_len_d;
      err_ck_q         <= err_ck_d;
    end
  end

  assign bus.pkt_type         = pkt_type_q;
  assign bus.pkt_id           = pkt_id_q;
  assign bus.pkt_data         = pkt_data;
  assign bus.pkt_end          = pkt_data && (byte_count_q == byte_count_max_q);
  assign bus.err              = (state_q == S_ERROR);
  assign bus.err_pkt_version  = err_ver_q;
  assign bus.err_pkt_type     = err_type_q;
  assign bus.err_pkt_len      = err_len_q;
  assign bus.err_pkt_checksum = err_ck_q;

endmodule
